io_mmio_ctrl: RTL and testbench

//  Memory-mapped I/O controller for the data-memory stage, downstream of the pipeline register.

---
 rtl/io_mmio_pkg.sv | 42 ++++
 rtl/io_mmio_ctrl_if.sv | 21 ++
 rtl/io_mmio_ctrl_key_debouncer.sv | 111 +++++++++++
 rtl/io_mmio_ctrl.sv | 103 ++++++++++
 tb/tb_io_mmio_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_mmio_pkg.sv
// Shared definitions for the MMIO controller: register addresses, debouncer
// state encoding and the address decoder used by the top level.
package io_mmio_pkg;

    localparam logic [31:0] ADDR_HEX   = 32'hF000_0000;
    localparam logic [31:0] ADDR_LEDR  = 32'hF000_0004;
    localparam logic [31:0] ADDR_LEDG  = 32'hF000_0008;
    localparam logic [31:0] ADDR_KEY   = 32'hF000_0010;
    localparam logic [31:0] ADDR_SW    = 32'hF000_0014;
    localparam logic [31:0] ADDR_KSTAT = 32'hF000_0018;

    typedef enum logic [1:0] {
        REL     = 2'd0,
        PRESS_W = 2'd1,
        PRS     = 2'd2,
        REL_W   = 2'd3
    } debState_e;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_HEX,
        SEL_LEDR,
        SEL_LEDG,
        SEL_KEY,
        SEL_SW,
        SEL_KSTAT
    } ioSel_e;

    // Word-granular decode: the byte offset within a word is ignored.
    function automatic ioSel_e decodeAddr(input logic [31:0] a);
        case ({a[31:2], 2'b00})
            ADDR_HEX:   return SEL_HEX;
            ADDR_LEDR:  return SEL_LEDR;
            ADDR_LEDG:  return SEL_LEDG;
            ADDR_KEY:   return SEL_KEY;
            ADDR_SW:    return SEL_SW;
            ADDR_KSTAT: return SEL_KSTAT;
            default:    return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/io_mmio_ctrl_if.sv
// Data-memory stage bus as seen by the I/O controller: registered address,
// write enable and store data in, combinational read data and hit flag out.
interface io_mmio_ctrl_if #(parameter int DBITS = 32);

    logic [DBITS-1:0] addr;
    logic             wrt_en;
    logic [DBITS-1:0] d_in;
    logic [DBITS-1:0] d_out;
    logic             io_hit;

    modport master (
        output addr, wrt_en, d_in,
        input  d_out, io_hit
    );

    modport slave (
        input  addr, wrt_en, d_in,
        output d_out, io_hit
    );

endinterface

// File: rtl/io_mmio_ctrl_key_debouncer.sv
// One key channel: 2-flop synchroniser plus, with IO_DEBOUNCE_EN defined, a
// stability FSM; press is high during the cycle before keyState rises.
module key_debouncer
    import io_mmio_pkg::*;
`ifdef IO_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int CNT_W        = 20
)
`endif
(
    input  logic clk,
    input  logic reset_n,
    input  logic pressedRaw,
    output logic keyState,
    output logic press
);

    logic sync1;
    logic sync2;

`ifdef IO_DEBOUNCE_EN

    debState_e        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic             cntDone;

    // The entry edge counts as the first stable sample, so the exit fires when
    // the count reaches DEBOUNCE_CYC-2 and DEBOUNCE_CYC samples have been seen.
    assign cntDone = (cnt == CNT_W'(DEBOUNCE_CYC - 2));
    assign cntNext = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    assign press   = (state == PRESS_W) && sync2 && cntDone;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            state    <= REL;
            cnt      <= '0;
            keyState <= 1'b0;
        end else begin
            sync1 <= pressedRaw;
            sync2 <= sync1;
            case (state)
                REL: begin
                    if (sync2) begin
                        state <= PRESS_W;
                        cnt   <= '0;
                    end else begin
                        cnt <= cntNext;
                    end
                end
                PRESS_W: begin
                    if (!sync2) begin
                        state <= REL;
                        cnt   <= '0;
                    end else if (cntDone) begin
                        state    <= PRS;
                        cnt      <= '0;
                        keyState <= 1'b1;
                    end else begin
                        cnt <= cntNext;
                    end
                end
                PRS: begin
                    if (!sync2) begin
                        state <= REL_W;
                        cnt   <= '0;
                    end else begin
                        cnt <= cntNext;
                    end
                end
                REL_W: begin
                    if (sync2) begin
                        state <= PRS;
                        cnt   <= '0;
                    end else if (cntDone) begin
                        state    <= REL;
                        cnt      <= '0;
                        keyState <= 1'b0;
                    end else begin
                        cnt <= cntNext;
                    end
                end
                default: begin
                    state <= REL;
                    cnt   <= '0;
                end
            endcase
        end
    end

`else

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pressedRaw;
            sync2 <= sync1;
        end
    end

    assign keyState = sync2;
    assign press    = sync1 & ~sync2;

`endif

endmodule

// File: rtl/io_mmio_ctrl.sv
// Memory-mapped I/O controller for the dmem stage: HEX/LEDR/LEDG registers,
// synchronised SW, debounced KEY and sticky W1C press flags. Macro: IO_DEBOUNCE_EN.
module io_mmio_ctrl
    import io_mmio_pkg::*;
#(
    parameter int DBITS        = 32,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int CNT_W        = 20
)
(
    input  logic              clk,
    input  logic              reset_n,
    io_mmio_ctrl_if.slave     bus,
    input  logic [9:0]        sw,
    input  logic [3:0]        key,
    output logic [15:0]       hex,
    output logic [9:0]        ledr,
    output logic [7:0]        ledg
);

    if (DEBOUNCE_CYC < 2 || (DEBOUNCE_CYC >> CNT_W) != 0) begin : g_badCfg
        $error("io_mmio_ctrl: need DEBOUNCE_CYC >= 2 and 2**CNT_W > DEBOUNCE_CYC");
    end

    ioSel_e           sel;
    logic [3:0]       keyState;
    logic [3:0]       pressEdge;
    logic [3:0]       pressFlag;
    logic [3:0]       clrMask;
    logic [9:0]       swSync1;
    logic [9:0]       swState;
    logic [DBITS-1:0] readData;
    logic             hit;
    logic             unusedBits;

    // Store data wider than the widest register is intentionally discarded.
    assign unusedBits = ^bus.d_in[DBITS-1:16];

    assign sel     = decodeAddr(bus.addr);
    assign clrMask = (bus.wrt_en && sel == SEL_KSTAT) ? bus.d_in[3:0] : 4'b0000;

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debouncer
`ifdef IO_DEBOUNCE_EN
        #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .CNT_W       (CNT_W)
        )
`endif
        u_deb (
            .clk       (clk),
            .reset_n   (reset_n),
            .pressedRaw(~key[i]),
            .keyState  (keyState[i]),
            .press     (pressEdge[i])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex       <= '0;
            ledr      <= '0;
            ledg      <= '0;
            pressFlag <= '0;
            swSync1   <= '0;
            swState   <= '0;
        end else begin
            swSync1   <= sw;
            swState   <= swSync1;
            // Clear first, then OR in new presses so a colliding press survives.
            pressFlag <= (pressFlag & ~clrMask) | pressEdge;
            if (bus.wrt_en) begin
                case (sel)
                    SEL_HEX:  hex  <= bus.d_in[15:0];
                    SEL_LEDR: ledr <= bus.d_in[9:0];
                    SEL_LEDG: ledg <= bus.d_in[7:0];
                    default:  ;
                endcase
            end
        end
    end

    // NOTE: defaults ahead of the case keep this block free of inferred latches.
    always_comb begin
        readData = '0;
        hit      = 1'b1;
        case (sel)
            SEL_HEX:   readData[15:0] = hex;
            SEL_LEDR:  readData[9:0]  = ledr;
            SEL_LEDG:  readData[7:0]  = ledg;
            SEL_KEY:   readData[3:0]  = keyState;
            SEL_SW:    readData[9:0]  = swState;
            SEL_KSTAT: readData[3:0]  = pressFlag;
            default:   hit            = 1'b0;
        endcase
    end

    assign bus.d_out  = readData;
    assign bus.io_hit = hit;

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Self-checking bench for io_mmio_ctrl: directed scenarios plus randomized
// traffic against a history-window reference model. Honours IO_DEBOUNCE_EN.
module tb_io_mmio_ctrl;

    localparam int DBITS = 32;
    localparam int DC    = 8;
    localparam int CW    = 4;
`ifdef IO_DEBOUNCE_EN
    localparam int LAT = 2 + DC;
`else
    localparam int LAT = 2;
`endif

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  sw      = '0;
    logic [3:0]  key     = 4'hF;
    logic [15:0] hex;
    logic [9:0]  ledr;
    logic [7:0]  ledg;

    io_mmio_ctrl_if #(.DBITS(DBITS)) bus ();

    io_mmio_ctrl #(
        .DBITS       (DBITS),
        .DEBOUNCE_CYC(DC),
        .CNT_W       (CW)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave),
        .sw     (sw),
        .key    (key),
        .hex    (hex),
        .ledr   (ledr),
        .ledg   (ledg)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: registers plus a per-cycle history of pressed pins.
    logic [15:0] mHex;
    logic [9:0]  mLedr;
    logic [7:0]  mLedg;
    logic [9:0]  mSw;
    logic [9:0]  mSwPrev;
    logic [3:0]  mKey;
    logic [3:0]  mFlag;
    logic [3:0]  mHist[$];

    task automatic modelReset();
        mHex = '0; mLedr = '0; mLedg = '0; mSw = '0; mSwPrev = '0;
        mKey = '0; mFlag = '0;
        mHist = {};
        for (int k = 0; k < DC + 2; k++) mHist.push_back(4'b0000);
    endtask

    // One rising edge: mHist[k] holds the pressed pins k edges ago.
    task automatic modelStep();
        logic [3:0] newKey;
        logic [3:0] rise;
        mHist.push_front(~key);
        void'(mHist.pop_back());
`ifdef IO_DEBOUNCE_EN
        // A key is accepted once DC consecutive synchronised samples agree.
        newKey = mKey;
        for (int i = 0; i < 4; i++) begin
            bit same = 1'b1;
            for (int k = 2; k <= DC + 1; k++)
                if (mHist[k][i] != mHist[2][i]) same = 1'b0;
            if (same) newKey[i] = mHist[2][i];
        end
`else
        newKey = mHist[1];
`endif
        rise    = newKey & ~mKey;
        mKey    = newKey;
        mSw     = mSwPrev;
        mSwPrev = sw;
        if (bus.wrt_en) begin
            case ({bus.addr[31:2], 2'b00})
                32'hF000_0000: mHex  = bus.d_in[15:0];
                32'hF000_0004: mLedr = bus.d_in[9:0];
                32'hF000_0008: mLedg = bus.d_in[7:0];
                32'hF000_0018: mFlag = mFlag & ~bus.d_in[3:0];
                default: ;
            endcase
        end
        mFlag = mFlag | rise;
    endtask

    function automatic logic [32:0] expRead(input logic [31:0] a);
        case ({a[31:2], 2'b00})
            32'hF000_0000: return {1'b1, 16'h0, mHex};
            32'hF000_0004: return {1'b1, 22'h0, mLedr};
            32'hF000_0008: return {1'b1, 24'h0, mLedg};
            32'hF000_0010: return {1'b1, 28'h0, mKey};
            32'hF000_0014: return {1'b1, 22'h0, mSw};
            32'hF000_0018: return {1'b1, 28'h0, mFlag};
            default:       return 33'h0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset_n) modelStep();
        #1;
    endtask

    task automatic doWrite(input logic [31:0] a, input logic [31:0] d);
        bus.addr   = a;
        bus.d_in   = d;
        bus.wrt_en = 1'b1;
        tick();
        bus.wrt_en = 1'b0;
    endtask

    task automatic readReg(input logic [31:0] a, output logic [31:0] d, output logic h);
        bus.addr   = a;
        bus.wrt_en = 1'b0;
        #1;
        d = bus.d_out;
        h = bus.io_hit;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        h;
        reset_n = 1'b0;
        modelReset();
        #12;
        @(posedge clk);
        #1 reset_n = 1'b1;
        vectors += 3;
        if (hex !== 16'h0)  begin miscompares++; $display("FAIL reset_hex: got %h want 0000", hex); end
        if (ledr !== 10'h0) begin miscompares++; $display("FAIL reset_ledr: got %h want 000", ledr); end
        if (ledg !== 8'h0)  begin miscompares++; $display("FAIL reset_ledg: got %h want 00", ledg); end
        readReg(32'hF000_0010, d, h);
        vectors++;
        if (d !== 32'h0 || h !== 1'b1) begin miscompares++; $display("FAIL reset_key: got %h/%b want 00000000/1", d, h); end
        readReg(32'hF000_0014, d, h);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL reset_sw: got %h want 00000000", d); end
        readReg(32'hF000_0018, d, h);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL reset_kstat: got %h want 00000000", d); end
    endtask

    task automatic test_writes();
        logic [31:0] d;
        logic        h;
        doWrite(32'hF000_0000, 32'hABCD_1234);
        vectors++;
        if (hex !== 16'h1234) begin miscompares++; $display("FAIL hex_write: got %h want 1234", hex); end
        readReg(32'hF000_0000, d, h);
        vectors++;
        if (d !== 32'h0000_1234 || h !== 1'b1) begin miscompares++; $display("FAIL hex_read: got %h/%b want 00001234/1", d, h); end
        doWrite(32'hF000_0004, 32'hFFFF_FFFF);
        vectors += 2;
        if (ledr !== 10'h3FF) begin miscompares++; $display("FAIL ledr_write: got %h want 3ff", ledr); end
        if (ledg !== 8'h00)   begin miscompares++; $display("FAIL ledg_untouched: got %h want 00", ledg); end
        readReg(32'hF000_0020, d, h);
        vectors++;
        if (d !== 32'h0 || h !== 1'b0) begin miscompares++; $display("FAIL unmapped_read: got %h/%b want 00000000/0", d, h); end
        doWrite(32'hF000_000B, 32'h0000_01A5);
        vectors++;
        if (ledg !== 8'hA5) begin miscompares++; $display("FAIL ledg_byteoff: got %h want a5", ledg); end
        doWrite(32'hF000_0010, 32'hFFFF_FFFF);
        doWrite(32'hF000_0020, 32'h0000_5555);
        readReg(32'hF000_0003, d, h);
        vectors += 4;
        if (d !== 32'h0000_1234 || h !== 1'b1) begin miscompares++; $display("FAIL hex_after_ro: got %h/%b want 00001234/1", d, h); end
        if (ledr !== 10'h3FF) begin miscompares++; $display("FAIL ledr_after_ro: got %h want 3ff", ledr); end
        if (ledg !== 8'hA5)   begin miscompares++; $display("FAIL ledg_after_ro: got %h want a5", ledg); end
        readReg(32'hF000_0010, d, h);
        if (d !== 32'h0) begin miscompares++; $display("FAIL key_ro: got %h want 00000000", d); end
    endtask

    task automatic test_key_bounce();
        logic [31:0] d;
        logic        h;
        key[2] = 1'b0; tick();
        key[2] = 1'b1; tick();
        key[2] = 1'b0;
        for (int c = 1; c <= LAT; c++) begin
            tick();
            readReg(32'hF000_0010, d, h);
            vectors++;
            if (d !== ((c >= LAT) ? 32'h4 : 32'h0)) begin
                miscompares++; $display("FAIL bounce_key c=%0d: got %h want %h", c, d, (c >= LAT) ? 4 : 0);
            end
            readReg(32'hF000_0018, d, h);
            vectors++;
            if (d !== {28'h0, mFlag}) begin
                miscompares++; $display("FAIL bounce_kstat c=%0d: got %h want %h", c, d, mFlag);
            end
        end
`ifdef IO_DEBOUNCE_EN
        vectors++;
        if (dut.pressFlag !== 4'h4) begin miscompares++; $display("FAIL bounce_single_press: got %h want 4", dut.pressFlag); end
`endif
        key[2] = 1'b1;
        for (int c = 1; c <= LAT; c++) begin
            tick();
            readReg(32'hF000_0010, d, h);
            vectors++;
            if (d !== ((c >= LAT) ? 32'h0 : 32'h4)) begin
                miscompares++; $display("FAIL release_key c=%0d: got %h want %h", c, d, (c >= LAT) ? 0 : 4);
            end
        end
        readReg(32'hF000_0018, d, h);
        vectors++;
        if (d !== 32'h4) begin miscompares++; $display("FAIL kstat_sticky: got %h want 00000004", d); end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] d;
        logic        h;
        doWrite(32'hF000_0018, 32'h4);
        readReg(32'hF000_0018, d, h);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL w1c_clear: got %h want 00000000", d); end
        key[2] = 1'b0;
        for (int c = 1; c < LAT; c++) tick();
        doWrite(32'hF000_0018, 32'h4);
        readReg(32'hF000_0018, d, h);
        vectors++;
        if (d !== 32'h4) begin miscompares++; $display("FAIL w1c_collide: got %h want 00000004", d); end
        readReg(32'hF000_0010, d, h);
        vectors++;
        if (d !== 32'h4) begin miscompares++; $display("FAIL collide_key: got %h want 00000004", d); end
        doWrite(32'hF000_0018, 32'h4);
        readReg(32'hF000_0018, d, h);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL w1c_alone: got %h want 00000000", d); end
        key[2] = 1'b1;
        for (int c = 0; c <= LAT; c++) tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic        h;
        doWrite(32'hF000_0000, 32'h55AA);
        doWrite(32'hF000_0004, 32'h2C3);
        doWrite(32'hF000_0008, 32'h7E);
        key[1] = 1'b0;
        for (int c = 0; c < LAT / 2; c++) tick();
        bus.addr = 32'hF000_0010;
        reset_n  = 1'b0;
        modelReset();
        #1;
        vectors += 4;
        if (hex !== 16'h0)  begin miscompares++; $display("FAIL midrst_hex: got %h want 0000", hex); end
        if (ledr !== 10'h0) begin miscompares++; $display("FAIL midrst_ledr: got %h want 000", ledr); end
        if (ledg !== 8'h0)  begin miscompares++; $display("FAIL midrst_ledg: got %h want 00", ledg); end
        if (bus.d_out !== 32'h0) begin miscompares++; $display("FAIL midrst_key: got %h want 00000000", bus.d_out); end
        key = 4'hF;
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int c = 0; c < LAT + 4; c++) tick();
        readReg(32'hF000_0018, d, h);
        vectors += 4;
        if (d !== 32'h0) begin miscompares++; $display("FAIL midrst_noflag: got %h want 00000000", d); end
        if (hex !== 16'h0)  begin miscompares++; $display("FAIL postrst_hex: got %h want 0000", hex); end
        if (ledr !== 10'h0) begin miscompares++; $display("FAIL postrst_ledr: got %h want 000", ledr); end
        if (ledg !== 8'h0)  begin miscompares++; $display("FAIL postrst_ledg: got %h want 00", ledg); end
    endtask

    task automatic test_sw_and_key0();
        logic [31:0] d;
        logic        h;
        sw = 10'h2A5;
        tick();
        readReg(32'hF000_0014, d, h);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL sw_lat1: got %h want 00000000", d); end
        tick();
        readReg(32'hF000_0014, d, h);
        vectors++;
        if (d !== 32'h2A5) begin miscompares++; $display("FAIL sw_lat2: got %h want 000002a5", d); end
        key[0] = 1'b0;
        for (int c = 1; c <= LAT; c++) begin
            tick();
            readReg(32'hF000_0018, d, h);
            vectors++;
            if (d[0] !== (c >= LAT)) begin
                miscompares++; $display("FAIL key0_flag c=%0d: got %b want %b", c, d[0], c >= LAT);
            end
        end
        key[0] = 1'b1;
        for (int c = 0; c <= LAT; c++) tick();
    endtask

    task automatic test_random();
        logic [31:0] addrTab[8];
        logic [32:0] e;
        addrTab = '{32'hF000_0000, 32'hF000_0004, 32'hF000_0008, 32'hF000_0010,
                    32'hF000_0014, 32'hF000_0018, 32'hF000_0020, 32'h1000_0018};
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(9) == 0) key[$urandom_range(3)] ^= 1'b1;
            if ($urandom_range(3) == 0) sw = 10'($urandom);
            bus.addr   = addrTab[$urandom_range(7)] | 32'($urandom_range(3));
            bus.wrt_en = ($urandom_range(2) == 0);
            bus.d_in   = $urandom;
            #1;
            e = expRead(bus.addr);
            vectors += 2;
            if (bus.d_out !== e[31:0] || bus.io_hit !== e[32]) begin
                miscompares++;
                $display("FAIL rand_read n=%0d addr=%h: got %h/%b want %h/%b", n, bus.addr, bus.d_out, bus.io_hit, e[31:0], e[32]);
            end
            if (hex !== mHex || ledr !== mLedr || ledg !== mLedg) begin
                miscompares++;
                $display("FAIL rand_outs n=%0d: got %h/%h/%h want %h/%h/%h", n, hex, ledr, ledg, mHex, mLedr, mLedg);
            end
            tick();
        end
        bus.wrt_en = 1'b0;
    endtask

    initial begin
        bus.addr   = '0;
        bus.wrt_en = 1'b0;
        bus.d_in   = '0;
        test_reset();
        test_writes();
        test_key_bounce();
        test_w1c_collision();
        test_reset_mid();
        test_sw_and_key0();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
